// File: rtl/wf_gather_queue.sv
`default_nettype none
// ============================================================================
//  Module      : wf_gather_queue
//  Description : Synchronous FIFO queue with a registered head-of-queue output
//                stage, occupancy count, almost-full flag and high-water mark.
//                Optional flow-through bypass is selected by the macro
//                WF_GATHER_QUEUE_BYPASS_EN (undefined: no enq->deq comb path).
//  Revision    : 1.0 - initial release
// ============================================================================
module wf_gather_queue #(
    parameter int DATA_W   = 38,
    parameter int DEPTH    = 8,
    parameter int AFULL_TH = 6,
    localparam int CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              enq_valid,
    output logic              enq_ready,
    input  logic [DATA_W-1:0] enq_data,
    output logic              deq_valid,
    input  logic              deq_ready,
    output logic [DATA_W-1:0] deq_data,
    output logic [CNT_W-1:0]  count,
    output logic              almost_full,
    output logic [CNT_W-1:0]  hwm
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] c_FULL  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_AFULL = CNT_W'(AFULL_TH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  r_hwm;
    logic              r_afull;
    logic [DATA_W-1:0] r_deq_data;

    logic              w_pass;
    logic              w_enq;
    logic              w_deq;
    logic [PTR_W-1:0]  w_wr_next;
    logic [PTR_W-1:0]  w_rd_next;
    logic [CNT_W-1:0]  w_cnt_next;
    logic [CNT_W-1:0]  w_hwm_next;
    logic [DATA_W-1:0] w_head_next;
    logic              w_load_head;

    // Transfer decode and next-state computation for pointers, count and head.
    always_comb begin
        w_pass = 1'b0;
`ifdef WF_GATHER_QUEUE_BYPASS_EN
        // Word flows straight from producer to consumer without being stored.
        w_pass = (r_count == '0) && enq_valid && deq_ready;
`endif
        w_enq = enq_valid && enq_ready && !w_pass && !flush;
        w_deq = (r_count != '0) && deq_ready && !flush;

        w_wr_next  = r_wr_ptr;
        w_rd_next  = r_rd_ptr;
        w_cnt_next = r_count;
        if (flush) begin
            w_wr_next  = '0;
            w_rd_next  = '0;
            w_cnt_next = '0;
        end else begin
            if (w_enq) w_wr_next = r_wr_ptr + PTR_W'(1);
            if (w_deq) w_rd_next = r_rd_ptr + PTR_W'(1);
            if (w_enq && !w_deq)      w_cnt_next = r_count + CNT_W'(1);
            else if (!w_enq && w_deq) w_cnt_next = r_count - CNT_W'(1);
        end

        if (flush)                    w_hwm_next = '0;
        else if (w_cnt_next > r_hwm)  w_hwm_next = w_cnt_next;
        else                          w_hwm_next = r_hwm;

        // The next head is the word being written now when it lands in the
        // slot the read pointer is about to point at (empty or single-entry).
        if (w_enq && (w_rd_next == r_wr_ptr)) w_head_next = enq_data;
        else                                  w_head_next = r_mem[w_rd_next];
        w_load_head = !flush && (w_cnt_next != '0);
    end

    // Storage array; contents are deliberately left unreset.
    always_ff @(posedge clock) begin
        if (w_enq) r_mem[r_wr_ptr] <= enq_data;
    end

    // Control state and the registered head-of-queue output stage.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_hwm      <= '0;
            r_afull    <= 1'b0;
            r_deq_data <= '0;
        end else begin
            r_wr_ptr <= w_wr_next;
            r_rd_ptr <= w_rd_next;
            r_count  <= w_cnt_next;
            r_hwm    <= w_hwm_next;
            r_afull  <= (w_cnt_next >= c_AFULL);
            if (w_load_head) r_deq_data <= w_head_next;
        end
    end

    // Output drive; the bypass build overlays the incoming word when empty.
    always_comb begin
        enq_ready   = (r_count < c_FULL);
        count       = r_count;
        hwm         = r_hwm;
        almost_full = r_afull;
        deq_valid   = (r_count != '0);
        deq_data    = r_deq_data;
`ifdef WF_GATHER_QUEUE_BYPASS_EN
        if ((r_count == '0) && enq_valid) begin
            deq_valid = 1'b1;
            deq_data  = enq_data;
        end
`endif
    end

endmodule
`default_nettype wire

// File: doc/wf_gather_queue.md
WF_GATHER_QUEUE -- requirements
Module: wf_gather_queue

Interface
REQ-001 Parameter DATA_W, default 38, payload width in bits, legal range >= 1.
REQ-002 Parameter DEPTH, default 8, storage entries; power of two, >= 2.
REQ-003 Parameter AFULL_TH, default 6, count at or above which almost_full asserts; legal range 1..DEPTH.
REQ-004 Local CNT_W = log2(DEPTH)+1.
REQ-005 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-006 Ports SHALL be, in order:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous discard of all contents.
- enq_valid  in  1  producer has data.
- enq_ready  out  1  queue can accept.
- enq_data  in  DATA_W  payload.
- deq_valid  out  1  head entry presented.
- deq_ready  in  1  consumer accepts head.
- deq_data  out  DATA_W  head payload.
- count  out  CNT_W  entries held.
- almost_full  out  1  count >= AFULL_TH.
- hwm  out  CNT_W  highest count reached since reset or flush.

Function
REQ-007 An enqueue SHALL occur on a rising edge when enq_valid && enq_ready; a dequeue when deq_valid && deq_ready.
REQ-008 Storage SHALL be a DEPTH-entry array with wrapping write and read pointers of log2(DEPTH) bits; wrap from DEPTH-1 to 0.
REQ-009 enq_ready SHALL equal (count < DEPTH), independent of deq_ready; a full queue never accepts in the same cycle it dequeues.
REQ-010 deq_data SHALL be driven from a registered output stage, so a word enqueued into an empty queue is presented with deq_valid=1 exactly one cycle later.
REQ-011 deq_valid SHALL be 1 iff count > 0, and deq_data SHALL hold the oldest unconsumed word, stable while deq_valid && !deq_ready.
REQ-012 count SHALL increment on enqueue-only, decrement on dequeue-only, and be unchanged on simultaneous enqueue and dequeue; it never exceeds DEPTH or underflows.
REQ-013 Words SHALL leave in strict FIFO order with no loss or duplication across pointer wrap.
REQ-014 almost_full SHALL be registered and equal (count >= AFULL_TH) for the current count.
REQ-015 hwm SHALL be updated to max(hwm, next count) every cycle.
REQ-016 flush SHALL have priority over enqueue and dequeue in the same cycle.
REQ-017 On the edge after flush=1, count, pointers and hwm SHALL be 0 and deq_valid 0. Any enqueue or dequeue presented in the flush cycle SHALL be discarded.
REQ-018 deq_data after flush SHALL hold its last value; it is don't-care while deq_valid=0.

Reset
REQ-019 When reset_n=0, the following SHALL apply immediately, irrespective of clock:
- count, hwm, and both pointers = 0.
- deq_valid = 0; almost_full = 0; deq_data = 0.
- enq_ready = 1.
REQ-020 Array contents SHALL NOT be reset.
REQ-021 Reset asserted mid-transfer SHALL discard all held entries. The first edge after reset_n rises SHALL behave as from empty.

Configuration
REQ-022 Macro WF_GATHER_QUEUE_BYPASS_EN SHALL select flow-through behaviour.
REQ-023 With WF_GATHER_QUEUE_BYPASS_EN defined, when count=0 and enq_valid=1:
- deq_valid=1 and deq_data=enq_data SHALL appear combinationally in the same cycle.
- If deq_ready=1, the word SHALL pass through without being stored: count and pointers unchanged, hwm unchanged.
- If deq_ready=0, it SHALL be stored as in REQ-010.
REQ-024 Without the macro, no combinational path from enq_* to deq_* SHALL exist; latency is per REQ-010.

Verification
REQ-025 Fill: the bench SHALL cover these directed scenarios (DEPTH=8, AFULL_TH=6) with the stated responses.
- Enqueue 0x00..0x07 with deq_ready=0 -> count=8, enq_ready=0, almost_full=1 from the edge where count reaches 6, hwm=8.
- Drain the full queue with deq_ready=1 -> outputs 0x00..0x07 in order, count=0, deq_valid=0, hwm stays 8.
REQ-026 Wrap: 20 words with enq and deq both continuously valid/ready -> in-order output.
- Count settles at 1 without bypass (0 with WF_GATHER_QUEUE_BYPASS_EN).
- Pointers wrap at least twice.
REQ-027 Full plus deq: at count=8, enq_valid=1, deq_ready=1 for one cycle -> one dequeue, no enqueue, count=7.
REQ-028 Flush: flush=1 with enq_valid=1 at count=5 -> next edge count=0, deq_valid=0, hwm=0, enqueued word discarded.
REQ-029 Reset: reset_n low mid-stream at count=3 -> outputs take reset values immediately without a clock. A subsequent single enqueue of 0x2A yields deq_data=0x2A one cycle later (same cycle with bypass).
